// File: rtl/ballot_collector.sv
// Polls four voters in turn, records each vote or a timeout abstention,
// then presents the collected ballot until the consumer accepts it.
module ballot_collector #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] vote_req,
  input  logic       vote_vld,
  input  logic       vote_val,
  output logic [3:0] ballot,
  output logic [3:0] abstain,
  output logic [2:0] yes_cnt,
  output logic       ballot_vld,
  input  logic       ballot_rdy,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_POLL    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_req;
  logic [3:0] r_ballot;
  logic [3:0] r_abstain;
  logic [2:0] r_yes;
  logic       r_vld;
  logic       r_busy;

  logic w_last;
  logic w_expired;
  logic w_advance;

  assign w_last    = (r_idx == 2'd3);
  assign w_expired = (r_cnt == LP_LAST);
  // A vote arriving on the expiry edge wins over the abstention.
  assign w_advance = vote_vld || w_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= 8'd0;
      r_req     <= 4'd0;
      r_ballot  <= 4'd0;
      r_abstain <= 4'd0;
      r_yes     <= 3'd0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_POLL;
            r_idx     <= 2'd0;
            r_cnt     <= 8'd0;
            r_req     <= 4'b0001;
            r_ballot  <= 4'd0;
            r_abstain <= 4'd0;
            r_yes     <= 3'd0;
            r_busy    <= 1'b1;
          end
        end
        S_POLL: begin
          if (vote_vld) begin
            r_ballot[r_idx] <= vote_val;
            r_yes           <= r_yes + {2'b00, vote_val};
          end else if (w_expired) begin
            r_ballot[r_idx]  <= 1'b0;
            r_abstain[r_idx] <= 1'b1;
          end
          if (w_advance) begin
            r_cnt <= 8'd0;
            if (w_last) begin
              r_state <= S_PRESENT;
              r_req   <= 4'd0;
              r_vld   <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
              r_req <= {r_req[2:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PRESENT: begin
          if (ballot_rdy) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 4'd0;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vote_req   = r_req;
  assign ballot     = r_ballot;
  assign abstain    = r_abstain;
  assign yes_cnt    = r_yes;
  assign ballot_vld = r_vld;
  assign busy       = r_busy;

endmodule
